// File: rtl/display_timing_pkg.sv
// Shared raster timing constants (640x480@60 defaults) and derivation helpers,
// imported by the timing generator and the sprite stages so the geometry stays consistent.
package display_timing_pkg;

    localparam int DEFAULT_COORDINATE_WIDTH = 10;
    localparam int DEFAULT_CLK_DIV          = 4;

    localparam int DEFAULT_H_RES  = 640;
    localparam int DEFAULT_H_FP   = 16;
    localparam int DEFAULT_H_SYNC = 96;
    localparam int DEFAULT_H_BP   = 48;

    localparam int DEFAULT_V_RES  = 480;
    localparam int DEFAULT_V_FP   = 10;
    localparam int DEFAULT_V_SYNC = 2;
    localparam int DEFAULT_V_BP   = 33;

    localparam int DEFAULT_H_POL    = 0;
    localparam int DEFAULT_V_POL    = 0;
    localparam int DEFAULT_LINE_POS = DEFAULT_H_RES;

    localparam int FRAME_COUNT_WIDTH = 16;

    function automatic int timing_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    localparam int DEFAULT_H_TOTAL = timing_total(DEFAULT_H_RES, DEFAULT_H_FP, DEFAULT_H_SYNC, DEFAULT_H_BP);
    localparam int DEFAULT_V_TOTAL = timing_total(DEFAULT_V_RES, DEFAULT_V_FP, DEFAULT_V_SYNC, DEFAULT_V_BP);

    // True when a non-negative value is representable in an unsigned field of the given width.
    function automatic bit fits_width(input int value, input int width);
        if (value < 0) begin
            return 1'b0;
        end
        if (width >= 31) begin
            return 1'b1;
        end
        return value < (1 << width);
    endfunction

endpackage

// File: rtl/display_timing_gen_pixel_tick_div.sv
// Pixel clock-enable divider: div_cnt runs 0..CLK_DIV-1 and tick is high on its last count.
module pixel_tick_div
    import display_timing_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_WIDTH = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] div_cnt;

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("pixel_tick_div: CLK_DIV must be at least 2");
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing source: pixel-rate horizontal/vertical counters with registered syncs,
// display enable and line/frame strobes. Define DISPLAY_TIMING_FRAME_CNT_EN to add frame_count.
module display_timing_gen
    import display_timing_pkg::*;
#(
    parameter int COORDINATE_WIDTH = DEFAULT_COORDINATE_WIDTH,
    parameter int CLK_DIV          = DEFAULT_CLK_DIV,
    parameter int H_RES            = DEFAULT_H_RES,
    parameter int H_FP             = DEFAULT_H_FP,
    parameter int H_SYNC           = DEFAULT_H_SYNC,
    parameter int H_BP             = DEFAULT_H_BP,
    parameter int V_RES            = DEFAULT_V_RES,
    parameter int V_FP             = DEFAULT_V_FP,
    parameter int V_SYNC           = DEFAULT_V_SYNC,
    parameter int V_BP             = DEFAULT_V_BP,
    parameter int H_POL            = DEFAULT_H_POL,
    parameter int V_POL            = DEFAULT_V_POL,
    parameter int LINE_POS         = DEFAULT_LINE_POS
) (
    input  logic                          clk,
    input  logic                          reset_button,
    output logic [COORDINATE_WIDTH-1:0]   horiz_pos,
    output logic [COORDINATE_WIDTH-1:0]   vert_pos,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic                          pix_tick,
    output logic                          line,
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    output logic                          frame,
    output logic [FRAME_COUNT_WIDTH-1:0]  frame_count
`else
    output logic                          frame
`endif
);

    localparam int H_TOTAL      = timing_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = timing_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = H_RES + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_RES + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [COORDINATE_WIDTH-1:0] H_LAST = COORDINATE_WIDTH'(H_TOTAL - 1);
    localparam logic [COORDINATE_WIDTH-1:0] V_LAST = COORDINATE_WIDTH'(V_TOTAL - 1);

    localparam logic HSYNC_ACTIVE = (H_POL != 0);
    localparam logic VSYNC_ACTIVE = (V_POL != 0);

    generate
        if (!fits_width(H_TOTAL - 1, COORDINATE_WIDTH)) begin : g_bad_h_total
            $error("display_timing_gen: H_TOTAL-1 does not fit in COORDINATE_WIDTH");
        end
        if (!fits_width(V_TOTAL - 1, COORDINATE_WIDTH)) begin : g_bad_v_total
            $error("display_timing_gen: V_TOTAL-1 does not fit in COORDINATE_WIDTH");
        end
        if (LINE_POS < 0 || LINE_POS >= H_TOTAL) begin : g_bad_line_pos
            $error("display_timing_gen: LINE_POS must lie within 0..H_TOTAL-1");
        end
    endgenerate

    logic                        tick;
    logic [COORDINATE_WIDTH-1:0] h_next;
    logic [COORDINATE_WIDTH-1:0] v_next;
    logic                        hsync_on;
    logic                        vsync_on;
    logic                        visible_next;
    logic                        wrap_to_origin;
    logic                        at_line_pos;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk  (clk),
        .rst  (reset_button),
        .tick (tick)
    );

    // Position the counters will hold after the next tick; every registered output is
    // decoded from this so syncs and strobes line up with the positions they describe.
    always_comb begin
        h_next = horiz_pos;
        v_next = vert_pos;
        if (horiz_pos == H_LAST) begin
            h_next = '0;
            if (vert_pos == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = vert_pos + 1'b1;
            end
        end else begin
            h_next = horiz_pos + 1'b1;
        end
    end

    assign hsync_on       = (int'(h_next) >= H_SYNC_START) && (int'(h_next) < H_SYNC_END);
    assign vsync_on       = (int'(v_next) >= V_SYNC_START) && (int'(v_next) < V_SYNC_END);
    assign visible_next   = (int'(h_next) < H_RES) && (int'(v_next) < V_RES);
    assign wrap_to_origin = (h_next == '0) && (v_next == '0);
    assign at_line_pos    = (int'(h_next) == LINE_POS);

    // Strobes are qualified by tick so they last one clk even though a position is held
    // for CLK_DIV clocks.
    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            horiz_pos <= '0;
            vert_pos  <= '0;
            hsync     <= ~HSYNC_ACTIVE;
            vsync     <= ~VSYNC_ACTIVE;
            de        <= 1'b0;
            pix_tick  <= 1'b0;
            line      <= 1'b0;
            frame     <= 1'b0;
        end else begin
            pix_tick <= tick;
            line     <= tick && at_line_pos;
            frame    <= tick && wrap_to_origin;
            if (tick) begin
                horiz_pos <= h_next;
                vert_pos  <= v_next;
                hsync     <= hsync_on ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
                vsync     <= vsync_on ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
                de        <= visible_next;
            end
        end
    end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    // Free-running frame counter for sprite animation; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            frame_count <= '0;
        end else if (tick && wrap_to_origin) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench for display_timing_gen on a shrunken 24x15 raster, comparing against a
// closed-form model that derives every output from the number of clocks since reset release.
module tb_display_timing_gen;

    localparam int CW  = 10;
    localparam int DIV = 4;
    localparam int HR  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VR  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int LP  = 16;
    localparam int HT  = HR + HF + HS + HB;
    localparam int VT  = VR + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * DIV;

    typedef struct {
        int k;
        int h;
        int v;
        int hs;
        int vs;
        int de;
        int tick;
        int ln;
        int fr;
        int fc;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_button = 1'b1;
    logic [CW-1:0] horiz_pos;
    logic [CW-1:0] vert_pos;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          pix_tick;
    logic          line;
    logic          frame;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_count;
`endif

    int total = 0;
    int bad   = 0;
    int k     = 0;

    display_timing_gen #(
        .COORDINATE_WIDTH (CW),
        .CLK_DIV          (DIV),
        .H_RES            (HR),
        .H_FP             (HF),
        .H_SYNC           (HS),
        .H_BP             (HB),
        .V_RES            (VR),
        .V_FP             (VF),
        .V_SYNC           (VS),
        .V_BP             (VB),
        .H_POL            (0),
        .V_POL            (0),
        .LINE_POS         (LP)
    ) dut (
        .clk          (clk),
        .reset_button (reset_button),
        .horiz_pos    (horiz_pos),
        .vert_pos     (vert_pos),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .pix_tick     (pix_tick),
        .line         (line),
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        .frame        (frame),
        .frame_count  (frame_count)
`else
        .frame        (frame)
`endif
    );

    always #5 clk = ~clk;

    // Pixel number p = clocks/DIV since release; position and flags follow from raster arithmetic.
    function automatic vec_t model(input int kk);
        vec_t e;
        int p;
        p      = kk / DIV;
        e.k    = kk;
        e.h    = p % HT;
        e.v    = (p / HT) % VT;
        e.tick = (kk > 0 && (kk % DIV) == 0) ? 1 : 0;
        e.hs   = (e.h >= HR + HF && e.h < HR + HF + HS) ? 0 : 1;
        e.vs   = (e.v >= VR + VF && e.v < VR + VF + VS) ? 0 : 1;
        e.de   = (p > 0 && e.h < HR && e.v < VR) ? 1 : 0;
        e.ln   = (e.tick == 1 && e.h == LP) ? 1 : 0;
        e.fr   = (e.tick == 1 && e.h == 0 && e.v == 0) ? 1 : 0;
        e.fc   = (p / (HT * VT)) % 65536;
        return e;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s at k=%0d: got %0d, want %0d", name, k, actual, expected);
        end
    endtask

    task automatic check_output(input vec_t e, input string tag);
        check({tag, ".horiz_pos"}, int'(horiz_pos), e.h);
        check({tag, ".vert_pos"},  int'(vert_pos),  e.v);
        check({tag, ".hsync"},     int'(hsync),     e.hs);
        check({tag, ".vsync"},     int'(vsync),     e.vs);
        check({tag, ".de"},        int'(de),        e.de);
        check({tag, ".pix_tick"},  int'(pix_tick),  e.tick);
        check({tag, ".line"},      int'(line),      e.ln);
        check({tag, ".frame"},     int'(frame),     e.fr);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        check({tag, ".frame_count"}, int'(frame_count), e.fc);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Holds reset for a few clocks, checks the reset state, then releases between edges.
    task automatic apply_stimulus();
        reset_button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output(model(0), "reset");
        @(negedge clk);
        reset_button = 1'b0;
        k = 0;
    endtask

    initial begin
        vec_t table_vecs[$];
        vec_t cur;
        int   line_cnt;
        int   frame_cnt;
        int   run_len;
        int   phase;

        table_vecs.push_back(vec_t'{3,    0,  0,  1, 1, 0, 0, 0, 0, 0});
        table_vecs.push_back(vec_t'{4,    1,  0,  1, 1, 1, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{5,    1,  0,  1, 1, 1, 0, 0, 0, 0});
        table_vecs.push_back(vec_t'{64,   16, 0,  1, 1, 0, 1, 1, 0, 0});
        table_vecs.push_back(vec_t'{65,   16, 0,  1, 1, 0, 0, 0, 0, 0});
        table_vecs.push_back(vec_t'{72,   18, 0,  0, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{80,   20, 0,  0, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{84,   21, 0,  1, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{92,   23, 0,  1, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{96,   0,  1,  1, 1, 1, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{960,  0,  10, 1, 0, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{1152, 0,  12, 1, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{1436, 23, 14, 1, 1, 0, 1, 0, 0, 0});
        table_vecs.push_back(vec_t'{1440, 0,  0,  1, 1, 1, 1, 0, 1, 1});
        table_vecs.push_back(vec_t'{1441, 0,  0,  1, 1, 1, 0, 0, 0, 1});

        apply_stimulus();
        foreach (table_vecs[i]) begin
            while (k < table_vecs[i].k) step();
            check_output(table_vecs[i], "table");
        end

        // Line/frame strobe counts over exactly one frame.
        apply_stimulus();
        line_cnt  = 0;
        frame_cnt = 0;
        repeat (FRAME_CLKS) begin
            step();
            line_cnt  += int'(line);
            frame_cnt += int'(frame);
        end
        check("line_pulses_per_frame", line_cnt, VT);
        check("frame_pulses_per_frame", frame_cnt, 1);

        // Reset asserted mid-line, mid-tick at position (10,5).
        apply_stimulus();
        while (k < 521) step();
        check("midline.horiz_pos", int'(horiz_pos), 10);
        check("midline.vert_pos", int'(vert_pos), 5);
        #3;
        reset_button = 1'b1;
        #1;
        check_output(model(0), "async_reset");
        apply_stimulus();
        repeat (8) begin
            step();
            check_output(model(k), "restart");
        end

        // Random run lengths and random reset phases, checked every clock.
        for (int iter = 0; iter < 6; iter++) begin
            apply_stimulus();
            run_len = int'($urandom_range(1, 3000));
            for (int i = 0; i < run_len; i++) begin
                step();
                check_output(model(k), "random");
            end
            phase = int'($urandom_range(1, 7));
            #(phase);
            reset_button = 1'b1;
            #1;
            check_output(model(0), "random_async_reset");
        end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        apply_stimulus();
        repeat (3 * FRAME_CLKS) step();
        check("frame_count_after_3", int'(frame_count), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
